uart_rx: RTL and testbench

UART receiver, the counterpart of the team's UART transmitter in the simple ARM SoC's UART peripheral. Samples the asynchronous rx line and recovers 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit. Delivers each byte with a one-cycle rx_end strobe and flags framing errors. Feeds the UART bus-interface block, which latches rx_data into its receive register on rx_end.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: state encodings, field widths and the
// helper that derives the mid-bit counter load from the divider rate.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int BYTE_DATA_W      = 8;
    localparam int UART_STATE_W     = 2;
    localparam int UART_DIV_CNT_W   = 9;
    localparam int UART_BIT_CNT_W   = 4;
    localparam int UART_BIT_CNT_MSB = 7;

    localparam logic [UART_STATE_W-1:0] UART_RX_IDLE  = 2'd0;
    localparam logic [UART_STATE_W-1:0] UART_RX_START = 2'd1;
    localparam logic [UART_STATE_W-1:0] UART_RX_DATA  = 2'd2;
    localparam logic [UART_STATE_W-1:0] UART_RX_STOP  = 2'd3;

    // Counter load that lands the first sample in the middle of the start bit.
    function automatic logic [UART_DIV_CNT_W-1:0] uart_div_rate_half(input int unsigned div_rate);
        return UART_DIV_CNT_W'(div_rate / 2);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for asynchronous inputs; resets to 1 so an idle-high
// line does not look like an edge coming out of reset.
`timescale 1ns/1ps
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised rx line, one-cycle
// rx_end strobe per byte, framing error flagged when the stop bit reads 0.
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_RATE    = 260,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic                   rx_busy,
    output logic                   rx_end,
    output logic [BYTE_DATA_W-1:0] rx_data,
    output logic                   rx_err
);

    localparam logic [UART_DIV_CNT_W-1:0] DIV_FULL = UART_DIV_CNT_W'(DIV_RATE);
    localparam logic [UART_DIV_CNT_W-1:0] DIV_HALF = uart_div_rate_half(DIV_RATE);

    logic                      rx_s;
    logic [UART_STATE_W-1:0]   state_q,   state_d;
    logic [UART_DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [UART_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_DATA_W-1:0]    sh_reg_q,  sh_reg_d;
    logic [BYTE_DATA_W-1:0]    rx_data_q, rx_data_d;
    logic                      rx_err_q,  rx_err_d;
    logic                      rx_end_q,  rx_end_d;
    logic                      tick;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick = (div_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_reg_d  = sh_reg_q;
        rx_data_d = rx_data_q;
        rx_err_d  = rx_err_q;
        rx_end_d  = DISABLE;

        case (state_q)
            UART_RX_IDLE: begin
                if (!rx_s) begin
                    state_d   = UART_RX_START;
                    div_cnt_d = DIV_HALF;
                end
            end
            UART_RX_START: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d   = UART_RX_DATA;
                    div_cnt_d = DIV_FULL;
                    bit_cnt_d = '0;
                end else begin
                    // Line went back high before mid-start: treat as a glitch.
                    state_d = UART_RX_IDLE;
                end
            end
            UART_RX_DATA: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    sh_reg_d  = {rx_s, sh_reg_q[BYTE_DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    div_cnt_d = DIV_FULL;
                    if (bit_cnt_q == UART_BIT_CNT_W'(UART_BIT_CNT_MSB)) begin
                        state_d = UART_RX_STOP;
                    end
                end
            end
            UART_RX_STOP: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    rx_data_d = sh_reg_q;
                    rx_err_d  = ~rx_s;
                    rx_end_d  = ENABLE;
                    state_d   = UART_RX_IDLE;
                end
            end
            default: begin
                state_d = UART_RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= UART_RX_IDLE;
            div_cnt_q <= DIV_HALF;
            bit_cnt_q <= '0;
            sh_reg_q  <= '0;
            rx_data_q <= '0;
            rx_err_q  <= DISABLE;
            rx_end_q  <= DISABLE;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_reg_q  <= sh_reg_d;
            rx_data_q <= rx_data_d;
            rx_err_q  <= rx_err_d;
            rx_end_q  <= rx_end_d;
        end
    end

    assign rx_busy = (state_q != UART_RX_IDLE);
    assign rx_end  = rx_end_q;
    assign rx_data = rx_data_q;
    assign rx_err  = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV_RATE=15 (16 clocks per bit): clean frames,
// back-to-back frames, framing error, glitch rejection, mid-frame reset, baud skew.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  DIV_RATE    = 15;
    localparam int  SYNC_STAGES = 2;
    localparam int  BIT_CYC     = DIV_RATE + 1;
    localparam real BIT_NS      = 160.0;
    // Drive starts 3ns before a posedge: sync stage 1, stage 2, then IDLE sees it,
    // then half a bit (DIV_RATE/2 + 1) to mid-start, then 9 full bits to mid-stop.
    localparam int  END_LATENCY = SYNC_STAGES + 1 + DIV_RATE/2 + 1 + 9*BIT_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rx_err;

    int         cyc = 0;
    int         checks_total = 0;
    int         checks_passed = 0;
    int         frame_start_cyc = 0;
    logic       busy_all;

    logic [7:0] end_data_q[$];
    logic       end_err_q[$];
    int         end_cyc_q[$];

    uart_rx #(
        .DIV_RATE    (DIV_RATE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_busy (rx_busy),
        .rx_end  (rx_end),
        .rx_data (rx_data),
        .rx_err  (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every rx_end strobe is logged with its payload and the cycle it was seen.
    always @(negedge clk) begin
        if (rx_end === 1'b1) begin
            end_data_q.push_back(rx_data);
            end_err_q.push_back(rx_err);
            end_cyc_q.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic alignToClock();
        @(negedge clk);
        #2;
    endtask

    task automatic clearLog();
        end_data_q.delete();
        end_err_q.delete();
        end_cyc_q.delete();
    endtask

    // Drives one frame; samples rx_busy at the middle of the start and data bits.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input real bit_ns);
        frame_start_cyc = cyc;
        busy_all = 1'b1;
        rx = 1'b0;
        #(bit_ns / 2.0);
        busy_all &= rx_busy;
        #(bit_ns / 2.0);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_ns / 2.0);
            busy_all &= rx_busy;
            #(bit_ns / 2.0);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] exp_data, input logic exp_err);
        logic [7:0] d;
        logic       e;
        checkOutput({tag, "_count"}, 32'(end_data_q.size()), 32'd1);
        if (end_data_q.size() > 0) begin
            d = end_data_q.pop_front();
            e = end_err_q.pop_front();
            void'(end_cyc_q.pop_front());
            checkOutput({tag, "_data"}, 32'(d), 32'(exp_data));
            checkOutput({tag, "_err"}, 32'(e), 32'(exp_err));
        end
    endtask

    initial begin
        int c0;
        int c1;
        real skew_ns[5];

        $display("[TB] uart_rx directed test start");
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 32'(rx_busy), 32'd0);
        checkOutput("reset_end",  32'(rx_end),  32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'h00);
        checkOutput("reset_err",  32'(rx_err),  32'd0);

        // Clean 0x55 with exact latency and busy across the frame
        clearLog();
        alignToClock();
        applyStimulus(8'h55, 1'b1, BIT_NS);
        c0 = frame_start_cyc;
        checkOutput("f55_busy", 32'(busy_all), 32'd1);
        if (end_cyc_q.size() > 0) begin
            checkOutput("f55_latency", 32'(end_cyc_q[0] - c0), 32'(END_LATENCY));
        end
        checkFrame("f55", 8'h55, 1'b0);
        repeat (2*BIT_CYC) @(negedge clk);
        checkOutput("f55_idle_busy", 32'(rx_busy), 32'd0);
        checkOutput("f55_hold_data", 32'(rx_data), 32'h55);

        // Back-to-back 0xA3 then 0x0F with no idle gap
        clearLog();
        alignToClock();
        applyStimulus(8'hA3, 1'b1, BIT_NS);
        applyStimulus(8'h0F, 1'b1, BIT_NS);
        repeat (BIT_CYC) @(negedge clk);
        checkOutput("b2b_count", 32'(end_data_q.size()), 32'd2);
        if (end_data_q.size() == 2) begin
            c0 = end_cyc_q[0];
            c1 = end_cyc_q[1];
            checkOutput("b2b_spacing", 32'(c1 - c0), 32'(10*BIT_CYC));
            checkOutput("b2b_data0", 32'(end_data_q[0]), 32'hA3);
            checkOutput("b2b_err0",  32'(end_err_q[0]),  32'd0);
            checkOutput("b2b_data1", 32'(end_data_q[1]), 32'h0F);
            checkOutput("b2b_err1",  32'(end_err_q[1]),  32'd0);
        end
        repeat (2*BIT_CYC) @(negedge clk);

        // 0xFF with a bad stop bit; the following break restart is a glitch
        clearLog();
        alignToClock();
        applyStimulus(8'hFF, 1'b0, BIT_NS);
        rx = 1'b1;
        repeat (3*BIT_CYC) @(negedge clk);
        checkFrame("ferr", 8'hFF, 1'b1);
        checkOutput("ferr_hold_data", 32'(rx_data), 32'hFF);
        checkOutput("ferr_hold_err",  32'(rx_err),  32'd1);
        checkOutput("ferr_idle_busy", 32'(rx_busy), 32'd0);

        // Three-clock low glitch must be rejected
        clearLog();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        checkOutput("glitch_busy_seen", 32'(rx_busy), 32'd1);
        repeat (DIV_RATE/2 + SYNC_STAGES + 2 - 3) @(negedge clk);
        checkOutput("glitch_busy_clear", 32'(rx_busy), 32'd0);
        repeat (2*BIT_CYC) @(negedge clk);
        checkOutput("glitch_no_end", 32'(end_data_q.size()), 32'd0);

        // Reset asserted during data bit 4 of 0x3C and held to the end of that frame
        clearLog();
        alignToClock();
        fork
            applyStimulus(8'h3C, 1'b1, BIT_NS);
            begin
                #(5.5 * BIT_NS);
                reset = 1'b1;
                #(5.0 * BIT_NS);
            end
        join
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_end",   32'(end_data_q.size()), 32'd0);
        checkOutput("rst_busy",     32'(rx_busy), 32'd0);
        checkOutput("rst_data_clr", 32'(rx_data), 32'h00);
        alignToClock();
        applyStimulus(8'h81, 1'b1, BIT_NS);
        repeat (BIT_CYC) @(negedge clk);
        checkFrame("rst_next", 8'h81, 1'b0);

        // Bit period skewed by -3%, -1.5%, 0, +1.5%, +3%
        skew_ns[0] = 155.2;
        skew_ns[1] = 157.6;
        skew_ns[2] = 160.0;
        skew_ns[3] = 162.4;
        skew_ns[4] = 164.8;
        for (int k = 0; k < 5; k++) begin
            clearLog();
            repeat (2*BIT_CYC) @(negedge clk);
            alignToClock();
            applyStimulus(8'h96, 1'b1, skew_ns[k]);
            repeat (BIT_CYC) @(negedge clk);
            checkFrame($sformatf("skew%0d", k), 8'h96, 1'b0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
